// File: rtl/e32_host_controller_if.sv
// Byte-stream link between the E32 host controller (master) and its UART (slave).
interface e32_host_controller_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/e32_host_controller.sv
// E32 transceiver host initiator: enters program mode, writes or reads the 5-byte
// configuration over the UART byte stream, checks the reply and restores mode 0.
module e32_host_controller #(
  parameter int                    DATA_WIDTH       = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD_WRITE       = 8'hC0,
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG_CMD   = 8'hC1,
  parameter int                    AUX_GUARD_CYCLES = 5000,
  parameter int                    AUX_TIMEOUT      = 1500000,
  parameter int                    RESP_TIMEOUT     = 100000
) (
  input  logic                      device_clk,
  input  logic                      rst,
  input  logic                      cmd_start,
  input  logic                      cmd_op,
  input  logic [5*DATA_WIDTH-1:0]   cfg_in,
  input  logic                      AUX,
  output logic                      M0,
  output logic                      M1,
  e32_host_controller_if.master     uart,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                error,
  output logic [5*DATA_WIDTH-1:0]   cfg_out
);
  localparam int DW     = DATA_WIDTH;
  localparam int MAX_AG = (AUX_TIMEOUT > AUX_GUARD_CYCLES) ? AUX_TIMEOUT : AUX_GUARD_CYCLES;
  localparam int MAX_T  = (MAX_AG > RESP_TIMEOUT) ? MAX_AG : RESP_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] AUX_LIM   = CNT_W'(AUX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(AUX_GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LIM  = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_SET_PROG, S_WAIT_AUX_P, S_GUARD_P, S_SEND,
    S_RECV, S_RESTORE, S_WAIT_AUX_N, S_GUARD_N, S_FINISH
  } state_t;

  typedef enum logic [1:0] {ERR_OK, ERR_AUX, ERR_MISMATCH, ERR_RESP} err_t;

  state_t             state, state_next;
  err_t               err_q;
  logic               aux_meta, aux_sync;
  logic [CNT_W-1:0]   timer;
  logic [2:0]         byte_idx;
  logic               op_lat;
  logic [5*DW-1:0]    cfg_lat;
  logic [4*DW-1:0]    rx_payload;
  logic [DW-1:0]      cfg_byte, tx_byte;
  logic               rx_mismatch, tx_fire, rx_take;
  logic               aux_hit, guard_hit, resp_hit;
  logic [2:0]         last_tx;

  assign error = err_q;

  // Payload byte addressed by byte_idx 1..5 (ADDH first); doubles as the echo reference.
  always_comb begin
    cfg_byte = '0;
    case (byte_idx)
      3'd1:    cfg_byte = cfg_lat[5*DW-1 -: DW];
      3'd2:    cfg_byte = cfg_lat[4*DW-1 -: DW];
      3'd3:    cfg_byte = cfg_lat[3*DW-1 -: DW];
      3'd4:    cfg_byte = cfg_lat[2*DW-1 -: DW];
      3'd5:    cfg_byte = cfg_lat[DW-1 -: DW];
      default: cfg_byte = '0;
    endcase
  end

  assign tx_byte     = op_lat ? RET_CONFIG_CMD : ((byte_idx == 3'd0) ? HEAD_WRITE : cfg_byte);
  assign rx_mismatch = (byte_idx == 3'd0) ? (uart.rx_data != HEAD_WRITE)
                                          : (!op_lat && (uart.rx_data != cfg_byte));
  assign last_tx     = op_lat ? 3'd2 : 3'd5;
  assign tx_fire     = (state == S_SEND) && uart.tx_ready;
  assign rx_take     = (state == S_RECV) && uart.rx_valid;
  assign aux_hit     = (timer == AUX_LIM);
  assign guard_hit   = (timer == GUARD_LIM);
  assign resp_hit    = (timer == RESP_LIM);

  always_ff @(posedge device_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    uart.tx_valid = 1'b0;
    uart.tx_data  = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_start) state_next = S_SET_PROG;
      end
      S_SET_PROG: state_next = S_WAIT_AUX_P;
      S_WAIT_AUX_P: begin
        if (aux_sync)     state_next = S_GUARD_P;
        else if (aux_hit) state_next = S_RESTORE;
      end
      S_GUARD_P: begin
        if (!aux_sync)      state_next = S_WAIT_AUX_P;
        else if (guard_hit) state_next = S_SEND;
      end
      S_SEND: begin
        uart.tx_valid = 1'b1;
        uart.tx_data  = tx_byte;
        if (tx_fire && (byte_idx == last_tx)) state_next = S_RECV;
      end
      S_RECV: begin
        if (rx_take) begin
          if (byte_idx == 3'd5) state_next = S_RESTORE;
        end else if (resp_hit) begin
          state_next = S_RESTORE;
        end
      end
      S_RESTORE: state_next = S_WAIT_AUX_N;
      S_WAIT_AUX_N: begin
        if (aux_sync)     state_next = S_GUARD_N;
        else if (aux_hit) state_next = S_FINISH;
      end
      S_GUARD_N: begin
        if (!aux_sync)      state_next = S_WAIT_AUX_N;
        else if (guard_hit) state_next = S_FINISH;
      end
      S_FINISH: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge device_clk) begin
    if (rst) begin
      aux_meta <= 1'b0;
      aux_sync <= 1'b0;
      timer    <= '0;
      byte_idx <= '0;
      err_q    <= ERR_OK;
      cfg_out  <= '0;
      M1       <= 1'b0;
      M0       <= 1'b0;
    end else begin
      aux_meta <= AUX;
      aux_sync <= aux_meta;

      // One shared timer: each waiting state starts from zero; a received byte restarts the gap.
      if ((state_next != state) || rx_take) timer <= '0;
      else if (timer != CNT_MAX)            timer <= timer + 1'b1;

      if (state_next != state)     byte_idx <= '0;
      else if (tx_fire || rx_take) byte_idx <= byte_idx + 1'b1;

      case (state)
        S_IDLE:       if (cmd_start) err_q <= ERR_OK;
        S_SET_PROG:   {M1, M0} <= 2'b11;
        S_WAIT_AUX_P: if (!aux_sync && aux_hit) err_q <= ERR_AUX;
        S_WAIT_AUX_N: if (!aux_sync && aux_hit && (err_q == ERR_OK)) err_q <= ERR_AUX;
        S_RECV: begin
          if (rx_take) begin
            if (rx_mismatch) err_q <= ERR_MISMATCH;
            if ((byte_idx == 3'd5) && (err_q == ERR_OK) && !rx_mismatch)
              cfg_out <= {rx_payload, uart.rx_data};
          end else if (resp_hit) begin
            err_q <= ERR_RESP;
          end
        end
        S_RESTORE:    {M1, M0} <= 2'b00;
        default:      ;
      endcase
    end
  end

  // NOTE: pure data registers skip reset; each is written before any state reads it.
  always_ff @(posedge device_clk) begin
    if ((state == S_IDLE) && cmd_start) begin
      op_lat  <= cmd_op;
      cfg_lat <= cfg_in;
    end
    if (rx_take) rx_payload <= {rx_payload[3*DW-1:0], uart.rx_data};
  end
endmodule

// File: tb/tb_e32_host_controller.sv
// Self-checking bench for e32_host_controller: AUX/UART models plus a rule-level
// reference for the expected frame, result code and cfg_out.
module tb_e32_host_controller;
  localparam int GUARD     = 20;
  localparam int AUX_TO    = 400;
  localparam int RESP_TO   = 200;
  localparam int AUX_DELAY = 100;

  logic        device_clk = 1'b0;
  logic        rst, cmd_start, cmd_op;
  logic [39:0] cfg_in, cfg_out;
  logic        AUX = 1'b1;
  logic        M0, M1, busy, done;
  logic [1:0]  error;

  e32_host_controller_if #(.DATA_WIDTH(8)) uart ();

  e32_host_controller #(
    .AUX_GUARD_CYCLES(GUARD), .AUX_TIMEOUT(AUX_TO), .RESP_TIMEOUT(RESP_TO)
  ) dut (
    .device_clk(device_clk), .rst(rst), .cmd_start(cmd_start), .cmd_op(cmd_op),
    .cfg_in(cfg_in), .AUX(AUX), .M0(M0), .M1(M1), .uart(uart),
    .busy(busy), .done(done), .error(error), .cfg_out(cfg_out)
  );

  always #5 device_clk = ~device_clk;

  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  logic [7:0] tx_log[$];
  logic       aux_stuck = 1'b0;
  logic [1:0] last_mode = 2'b00;
  int         aux_cnt = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] held_byte;
  logic [39:0] model_cfg = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Module model: AUX drops on every mode change and rises AUX_DELAY cycles later.
  always @(negedge device_clk) begin
    if ({M1, M0} !== last_mode) begin
      last_mode = {M1, M0};
      aux_cnt   = AUX_DELAY;
    end else if (aux_cnt > 0) begin
      aux_cnt--;
    end
    AUX = !aux_stuck && (aux_cnt == 0);
  end

  // UART model: random back-pressure, logs accepted bytes, checks tx_data holds while stalled.
  always @(negedge device_clk) begin
    uart.tx_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (hold_pending && uart.tx_valid) check("tx_hold", uart.tx_data, held_byte);
    hold_pending = uart.tx_valid && !uart.tx_ready;
    held_byte    = uart.tx_data;
    if (uart.tx_valid && uart.tx_ready) tx_log.push_back(uart.tx_data);
  end

  always @(negedge device_clk) if (done === 1'b1) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic start_cmd(input logic op, input logic [39:0] cfg);
    @(negedge device_clk);
    cmd_op = op; cfg_in = cfg; cmd_start = 1'b1;
    @(negedge device_clk);
    cmd_start = 1'b0;
    check("busy_n1", busy, 1'b1);
    check("mode_n1", {M1, M0}, 2'b00);
    @(negedge device_clk);
    check("mode_n2", {M1, M0}, 2'b11);
  endtask

  task automatic wait_tx(input int n, input int bound);
    int cyc = 0;
    while (tx_log.size() < n && cyc < bound) begin
      @(negedge device_clk); #2; cyc++;
    end
    check("tx_count", tx_log.size(), n);
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = 0;
    do begin @(negedge device_clk); cyc++; end while (done !== 1'b1 && cyc < bound);
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    @(negedge device_clk);
    check("done_pulse", done, 1'b0);
  endtask

  // Full transaction against the reference rules; nsend bytes of resp are returned (7th = 8'hEE).
  task automatic run_txn(input string tag, input logic op, input logic [39:0] cfg,
                         input logic [47:0] resp, input int nsend, input logic stray);
    logic [47:0] obs = '0;
    logic [1:0]  exp_err;
    int          cyc;
    tx_log.delete();
    start_cmd(op, cfg);
    wait_tx(op ? 3 : 6, 5000);
    foreach (tx_log[i]) obs = {obs[39:0], tx_log[i]};
    check({tag, "_tx"}, obs, op ? 48'hC1C1C1 : {8'hC0, cfg});
    if (stray) begin
      uart.rx_data = 8'h55; uart.rx_valid = 1'b1;
      @(negedge device_clk);
      uart.rx_valid = 1'b0;
    end
    for (int i = 0; i < nsend; i++) begin
      @(negedge device_clk);
      uart.rx_data  = (i < 6) ? resp[8*(5-i) +: 8] : 8'hEE;
      uart.rx_valid = 1'b1;
      @(negedge device_clk);
      uart.rx_valid = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge device_clk);
    end
    wait_done(3000, cyc);
    if (nsend < 6)                                                 exp_err = 2'b11;
    else if (resp[47:40] != 8'hC0 || (!op && resp[39:0] != cfg)) exp_err = 2'b10;
    else                                                           exp_err = 2'b00;
    if (exp_err == 2'b00) model_cfg = resp[39:0];
    if (nsend < 6) check({tag, "_resp_gap"}, (cyc >= RESP_TO), 1'b1);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_cfg_out"}, cfg_out, model_cfg);
    check({tag, "_mode"}, {M1, M0}, 2'b00);
  endtask

  initial begin
    int          cyc, kind, pos, dseen;
    logic        op;
    logic [39:0] cfg;
    logic [47:0] resp;

    rst = 1'b1; cmd_start = 1'b0; cmd_op = 1'b0; cfg_in = '0;
    uart.rx_valid = 1'b0; uart.rx_data = '0;
    repeat (3) @(negedge device_clk);
    check("rst_mode", {M1, M0}, 2'b00);
    check("rst_tx_valid", uart.tx_valid, 1'b0);
    check("rst_tx_data", uart.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 2'b00);
    check("rst_cfg_out", cfg_out, 40'h0);
    rst = 1'b0;
    repeat (120) @(negedge device_clk);

    run_txn("write", 1'b0, 40'h0000_1A17_44, 48'hC0_0000_1A17_44, 6, 1'b1);
    run_txn("read", 1'b1, 40'h0, 48'hC0_1234_1A17_44, 6, 1'b0);
    run_txn("bad_echo", 1'b0, 40'h0000_1A17_44, 48'hC0_0000_1A18_44, 7, 1'b0);
    run_txn("dropout", 1'b0, 40'h0000_1A17_44, 48'hC0_0000_1A17_44, 3, 1'b0);

    // AUX never rises: both mode changes time out, result stays AUX timeout.
    aux_stuck = 1'b1;
    tx_log.delete();
    start_cmd(1'b0, 40'h0102030405);
    wait_done(3000, cyc);
    check("stuck_duration", (cyc >= 2 * AUX_TO), 1'b1);
    check("stuck_error", error, 2'b01);
    check("stuck_cfg_out", cfg_out, model_cfg);
    check("stuck_mode", {M1, M0}, 2'b00);
    check("stuck_no_tx", tx_log.size(), 0);
    aux_stuck = 1'b0;
    repeat (5) @(negedge device_clk);

    for (int t = 0; t < 6; t++) begin
      op   = 1'($urandom_range(0, 1));
      cfg  = {8'($urandom_range(0, 255)), 32'($urandom)};
      resp = op ? {8'hC0, 8'($urandom_range(0, 255)), 32'($urandom)} : {8'hC0, cfg};
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        pos  = $urandom_range(0, 5);
        resp = resp ^ (48'($urandom_range(1, 255)) << (8 * (5 - pos)));
      end
      run_txn("rand", op, cfg, resp, (kind == 3) ? $urandom_range(0, 5) : 6, 1'b0);
    end

    // Second start while busy must not change the frame; reset in the 3rd byte aborts cleanly.
    tx_log.delete();
    start_cmd(1'b0, 40'hA1B2C3D4E5);
    repeat (5) @(negedge device_clk);
    cmd_op = 1'b1; cfg_in = 40'h0; cmd_start = 1'b1;
    @(negedge device_clk);
    cmd_start = 1'b0;
    wait_tx(2, 5000);
    check("busy_start_b0", tx_log[0], 8'hC0);
    check("busy_start_b1", tx_log[1], 8'hA1);
    @(negedge device_clk);
    check("third_valid", uart.tx_valid, 1'b1);
    check("third_data", uart.tx_data, 8'hB2);
    dseen = done_seen;
    rst = 1'b1;
    @(negedge device_clk);
    check("abort_tx_valid", uart.tx_valid, 1'b0);
    check("abort_mode", {M1, M0}, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_cfg_out", cfg_out, 40'h0);
    rst = 1'b0;
    repeat (300) @(negedge device_clk);
    check("abort_no_done", done_seen, dseen);
    check("abort_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e32_host_controller.md
# e32_host_controller

Host-side initiator for the E32-style RF transceiver's MCU interface. It drives M0/M1, follows AUX, and writes or reads the module's 5-byte configuration over a byte-stream UART port. Writes use the volatile-less head C0; reads use the return-config command C1 C1 C1. The block sits on the MCU side in front of a com_uart instance. It turns a single start request into the full mode-3 program sequence and returns the module to mode 0 afterwards.

## Interface
- DATA_WIDTH, 8, UART byte width.
- HEAD_WRITE, 8'hC0, write-config head byte; also the expected response head.
- RET_CONFIG_CMD, 8'hC1, read-config command byte, sent 3 times.
- AUX_GUARD_CYCLES, 5000, cycles to wait after synced AUX is seen high, before the next action.
- AUX_TIMEOUT, 1500000, maximum cycles to wait for AUX high.
- RESP_TIMEOUT, 100000, maximum cycles between response bytes. The first byte is timed from the last TX byte accepted.
- device_clk  in  1  single clock; every flop is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle request. Sampled only in IDLE.
- cmd_op  in  1  0 = write config, 1 = read config. Captured with cmd_start.
- cfg_in  in  40  {ADDH, ADDL, SPED, CHAN, OPTION}. Captured with cmd_start. ADDH is sent first.
- AUX  in  1  module-ready signal, asynchronous. Passed through a 2-flop synchronizer.
- M0, M1  out  1 each  module mode pins.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  byte available on tx_data.
- tx_ready  in  1  UART accepts the byte in any cycle where tx_valid and tx_ready are both high.
- rx_data  in  8  byte from the UART.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- busy  out  1  high from the cycle after cmd_start is accepted until done.
- done  out  1  one-cycle completion pulse.
- error  out  2  result code, valid with done and held until the next accept. 00 ok, 01 AUX timeout, 10 response mismatch, 11 response timeout.
- cfg_out  out  40  the 5 payload bytes received, same byte order as cfg_in. Updated only when error = 00.

## Operation
- Reset values:
  - M1 = 0, M0 = 0.
  - tx_valid = 0, tx_data = 0.
  - busy = 0, done = 0, error = 00, cfg_out = 0.
  - State = IDLE, all counters 0.
- States and transitions:
  - IDLE: on cmd_start, latch cmd_op and cfg_in, clear error, and go to SET_PROG.
  - SET_PROG: drive M1 = 1, M0 = 1, then go to WAIT_AUX_P.
  - WAIT_AUX_P: wait for synced AUX = 1, then go to GUARD_P. If AUX_TIMEOUT expires, set error = 01 and go to RESTORE.
  - GUARD_P: count AUX_GUARD_CYCLES. If synced AUX drops during the count, return to WAIT_AUX_P with the timeout counter cleared. When the count completes, go to SEND.
  - SEND:
    - Write: 6 bytes, HEAD_WRITE then cfg bytes ADDH to OPTION.
    - Read: 3 bytes of RET_CONFIG_CMD.
    - tx_valid stays high and tx_data stays stable until the byte is accepted. The next byte is presented in the cycle after acceptance.
    - After the last byte is accepted, go to RECV.
  - RECV:
    - Collect 6 bytes on rx_valid. Byte 0 must equal HEAD_WRITE. For a write, bytes 1–5 must also equal the latched cfg.
    - Any mismatch sets error = 10. The remaining bytes are still collected.
    - A gap longer than RESP_TIMEOUT sets error = 11 and goes to RESTORE.
    - After the 6th byte, update cfg_out if error = 00, then go to RESTORE.
  - RESTORE: drive M1 = 0, M0 = 0, then go to WAIT_AUX_N.
  - WAIT_AUX_N: same behaviour as WAIT_AUX_P. On timeout, set error = 01 only if error is still 00.
  - GUARD_N: same behaviour as GUARD_P.
  - FINISH: pulse done, drop busy, go to IDLE.
- Receive-side rules:
  - rx_valid outside RECV is ignored.
  - Bytes beyond the 6th are ignored.
  - An rx_valid in the same cycle as the last TX acceptance is ignored; RECV starts on the next cycle.
- cmd_start while busy is ignored, with no queueing.
- Counters are sized with $clog2 of the maximum of the three timing parameters plus 1. They saturate and never wrap.

## Timing
- cmd_start accepted in cycle N:
  - busy = 1 at N+1.
  - M1 = M0 = 1 at N+2.
- The synchronizer adds 2 cycles of AUX latency.
- Guard exit to first tx_valid: 1 cycle.
- done is asserted in the cycle after GUARD_N completes. busy = 0 in that same cycle.
- Reset mid-operation: all outputs take their reset values on the next edge, including M1 = M0 = 0 immediately. No done pulse.

## Test plan
- Write path:
  - Stimulus: cmd_op = 0, cfg_in = 40'h0000_1A17_44. The AUX model goes high 100 cycles after each mode change, and the responder echoes the frame.
  - Required: TX sequence C0 00 00 1A 17 44, then M1M0 = 00, done with error = 00, cfg_out = 40'h0000_1A17_44.
- Read path:
  - Stimulus: cmd_op = 1. Responder returns C0 12 34 1A 17 44.
  - Required: TX sequence C1 C1 C1, cfg_out = 40'h1234_1A17_44, error = 00.
- AUX stuck low:
  - Stimulus: AUX held at 0.
  - Required: error = 01 after AUX_TIMEOUT, M1M0 returns to 00, done after the second timeout, cfg_out unchanged.
- Bad echo:
  - Stimulus: write whose echo carries CHAN = 18.
  - Required: error = 10, all 6 bytes consumed, cfg_out unchanged.
- Response dropout:
  - Stimulus: responder sends only 3 bytes.
  - Required: error = 11 after RESP_TIMEOUT, mode restored to 00.
- Start while busy, then reset in SEND:
  - Stimulus: cmd_start while busy, then rst during the 3rd TX byte.
  - Required: the extra cmd_start has no effect; after rst, tx_valid = 0, M1M0 = 00, busy = 0 on the next edge, and no done pulse.
